// File: rtl/fifo_pkg.sv
// Shared width-conversion helpers: lane ratio, conversion direction and per-side unit sizes
// for FIFOs whose write and read widths differ by a power of two.
package fifo_pkg;

    localparam int MAX_RATIO = 32;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    function automatic int narrow_w(input int wr_w, input int rd_w);
        return (wr_w < rd_w) ? wr_w : rd_w;
    endfunction

    function automatic int wide_w(input int wr_w, input int rd_w);
        return (wr_w < rd_w) ? rd_w : wr_w;
    endfunction

    function automatic int lane_count(input int wr_w, input int rd_w);
        return wide_w(wr_w, rd_w) / narrow_w(wr_w, rd_w);
    endfunction

    function automatic bit is_upconv(input int wr_w, input int rd_w);
        return wr_w < rd_w;
    endfunction

    // Narrow-word units moved by one access on each side.
    function automatic int wr_units(input int wr_w, input int rd_w);
        return is_upconv(wr_w, rd_w) ? 1 : lane_count(wr_w, rd_w);
    endfunction

    function automatic int rd_units(input int wr_w, input int rd_w);
        return is_upconv(wr_w, rd_w) ? lane_count(wr_w, rd_w) : 1;
    endfunction

    function automatic int rd_depth_width(input int wr_depth_w, input int wr_w, input int rd_w);
        return wr_depth_w + clog2(wr_units(wr_w, rd_w)) - clog2(rd_units(wr_w, rd_w));
    endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// Simple dual-port RAM at wide width with per-lane write enables, registered read
// and an optional second output register.
module sync_fifo_ram #(
    parameter int LANE_W     = 32,
    parameter int LANES      = 8,
    parameter int ADDR_W     = 8,
    parameter int OUTPUT_REG = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [LANES-1:0]          we_i,
    input  logic [ADDR_W-1:0]         waddr_i,
    input  logic [LANES*LANE_W-1:0]   wdata_i,
    input  logic                      re_i,
    input  logic [ADDR_W-1:0]         raddr_i,
    output logic [LANES*LANE_W-1:0]   rdata_o
);
    localparam int WORD_W = LANES * LANE_W;
    localparam int DEPTH  = 1 << ADDR_W;

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [WORD_W-1:0] rd_p1_q;

    always_ff @(posedge clk) begin
        for (int l = 0; l < LANES; l++) begin
            if (we_i[l]) mem_q[waddr_i][l*LANE_W +: LANE_W] <= wdata_i[l*LANE_W +: LANE_W];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) rd_p1_q <= '0;
        else if (re_i) rd_p1_q <= mem_q[raddr_i];
    end

    generate
        if (OUTPUT_REG != 0) begin : g_oreg
            logic              vld_p1_q;
            logic [WORD_W-1:0] rd_p2_q;
            always_ff @(posedge clk) begin
                if (rst) begin
                    vld_p1_q <= 1'b0;
                    rd_p2_q  <= '0;
                end else begin
                    vld_p1_q <= re_i;
                    if (vld_p1_q) rd_p2_q <= rd_p1_q;
                end
            end
            assign rdata_o = rd_p2_q;
        end else begin : g_noreg
            assign rdata_o = rd_p1_q;
        end
    endgenerate

endmodule

// File: rtl/sync_width_conv_fifo.sv
// Single-clock FIFO with independent power-of-two related write/read widths; occupancy is
// tracked in narrow-word units and all flags are registered from the post-update count.
module sync_width_conv_fifo
    import fifo_pkg::*;
#(
    parameter int WR_DATA_WIDTH  = 256,
    parameter int RD_DATA_WIDTH  = 32,
    parameter int WR_DEPTH_WIDTH = 8,
    parameter int OUTPUT_REG     = 0,
    localparam int RD_DEPTH_WIDTH = rd_depth_width(WR_DEPTH_WIDTH, WR_DATA_WIDTH, RD_DATA_WIDTH)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [WR_DATA_WIDTH-1:0]  wr_data,
    output logic                      wr_full,
    output logic                      almost_full,
    output logic [WR_DEPTH_WIDTH:0]   wr_water_level,
    input  logic [WR_DEPTH_WIDTH:0]   almost_full_num,
    output logic                      wr_overflow,
    input  logic                      rd_en,
    output logic [RD_DATA_WIDTH-1:0]  rd_data,
    output logic                      rd_empty,
    output logic                      almost_empty,
    output logic [RD_DEPTH_WIDTH:0]   rd_water_level,
    input  logic [RD_DEPTH_WIDTH:0]   almost_empty_num,
    output logic                      rd_underflow
);
    localparam bit IS_UPCONV = is_upconv(WR_DATA_WIDTH, RD_DATA_WIDTH);
    localparam int NARROW_W  = narrow_w(WR_DATA_WIDTH, RD_DATA_WIDTH);
    localparam int WIDE_W    = wide_w(WR_DATA_WIDTH, RD_DATA_WIDTH);
    localparam int LANES     = lane_count(WR_DATA_WIDTH, RD_DATA_WIDTH);
    localparam int LANE_BITS = clog2(LANES);
    localparam int WR_UNITS  = wr_units(WR_DATA_WIDTH, RD_DATA_WIDTH);
    localparam int RD_UNITS  = rd_units(WR_DATA_WIDTH, RD_DATA_WIDTH);
    localparam int WR_SHIFT  = clog2(WR_UNITS);
    localparam int RD_SHIFT  = clog2(RD_UNITS);
    localparam int NPTR_W    = WR_DEPTH_WIDTH + WR_SHIFT;
    localparam int CNT_W     = NPTR_W + 1;
    localparam int ADDR_W    = NPTR_W - LANE_BITS;
    localparam int LSEL_W    = (LANE_BITS > 0) ? LANE_BITS : 1;
    localparam logic [CNT_W-1:0] CAPACITY = CNT_W'(1) << NPTR_W;

    logic [NPTR_W-1:0]       wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [WR_DEPTH_WIDTH:0] wr_lvl_d, wr_lvl_q;
    logic [RD_DEPTH_WIDTH:0] rd_lvl_d, rd_lvl_q;
    logic wr_full_q, rd_empty_q, almost_full_q, almost_empty_q, wr_overflow_q, rd_underflow_q;
    logic wr_acc, rd_acc;

    logic [LANES-1:0]  ram_we;
    logic [WIDE_W-1:0] ram_wdata, ram_rdata;

    assign wr_acc = wr_en && !wr_full_q && !rst;
    assign rd_acc = rd_en && !rd_empty_q && !rst;

    always_comb begin
        cnt_d = cnt_q;
        if (wr_acc) cnt_d = cnt_d + CNT_W'(WR_UNITS);
        if (rd_acc) cnt_d = cnt_d - CNT_W'(RD_UNITS);
        if (rst) cnt_d = '0;
        // Write side reports partially consumed wide words as still occupied (ceiling).
        wr_lvl_d = (WR_DEPTH_WIDTH + 1)'((cnt_d + CNT_W'(WR_UNITS - 1)) >> WR_SHIFT);
        rd_lvl_d = (RD_DEPTH_WIDTH + 1)'(cnt_d >> RD_SHIFT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (wr_acc) wr_ptr_q <= wr_ptr_q + NPTR_W'(WR_UNITS);
            if (rd_acc) rd_ptr_q <= rd_ptr_q + NPTR_W'(RD_UNITS);
        end
        cnt_q          <= cnt_d;
        wr_lvl_q       <= wr_lvl_d;
        rd_lvl_q       <= rd_lvl_d;
        wr_full_q      <= (CAPACITY - cnt_d) < CNT_W'(WR_UNITS);
        rd_empty_q     <= cnt_d < CNT_W'(RD_UNITS);
        almost_full_q  <= wr_lvl_d >= almost_full_num;
        almost_empty_q <= rd_lvl_d <= almost_empty_num;
        wr_overflow_q  <= !rst && wr_en && wr_full_q;
        rd_underflow_q <= !rst && rd_en && rd_empty_q;
    end

    generate
        if (IS_UPCONV) begin : g_up
            logic [LSEL_W-1:0] wr_lane;
            assign wr_lane = LSEL_W'(wr_ptr_q & NPTR_W'(LANES - 1));
            always_comb begin
                ram_we = '0;
                for (int l = 0; l < LANES; l++) ram_we[l] = wr_acc && (wr_lane == LSEL_W'(l));
            end
            assign ram_wdata = {LANES{wr_data}};
            assign rd_data   = ram_rdata;
        end else begin : g_down
            logic [LSEL_W-1:0] lane_p1_q, lane_p2_q, rd_lane;
            logic              vld_p1_q;
            // Lane index follows the RAM read pipeline so the mux lines up with its data.
            always_ff @(posedge clk) begin
                if (rst) begin
                    vld_p1_q  <= 1'b0;
                    lane_p1_q <= '0;
                    lane_p2_q <= '0;
                end else begin
                    vld_p1_q <= rd_acc;
                    if (rd_acc) lane_p1_q <= LSEL_W'(rd_ptr_q & NPTR_W'(LANES - 1));
                    if (vld_p1_q) lane_p2_q <= lane_p1_q;
                end
            end
            assign rd_lane   = (OUTPUT_REG != 0) ? lane_p2_q : lane_p1_q;
            assign ram_we    = {LANES{wr_acc}};
            assign ram_wdata = wr_data;
            assign rd_data   = ram_rdata[rd_lane*NARROW_W +: NARROW_W];
        end
    endgenerate

    sync_fifo_ram #(
        .LANE_W    (NARROW_W),
        .LANES     (LANES),
        .ADDR_W    (ADDR_W),
        .OUTPUT_REG(OUTPUT_REG)
    ) u_ram (
        .clk    (clk),
        .rst    (rst),
        .we_i   (ram_we),
        .waddr_i(ADDR_W'(wr_ptr_q >> LANE_BITS)),
        .wdata_i(ram_wdata),
        .re_i   (rd_acc),
        .raddr_i(ADDR_W'(rd_ptr_q >> LANE_BITS)),
        .rdata_o(ram_rdata)
    );

    assign wr_full        = wr_full_q;
    assign rd_empty       = rd_empty_q;
    assign almost_full    = almost_full_q;
    assign almost_empty   = almost_empty_q;
    assign wr_water_level = wr_lvl_q;
    assign rd_water_level = rd_lvl_q;
    assign wr_overflow    = wr_overflow_q;
    assign rd_underflow   = rd_underflow_q;

endmodule

// File: tb/tb_sync_width_conv_fifo.sv
// Bench for sync_width_conv_fifo: a queue-based model checks the 256->32 instance every cycle,
// directed literal checks pin both that model and a 32->256 instance with output register.
module tb_sync_width_conv_fifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic         d_wr_en, d_rd_en, d_wr_full, d_af, d_ovf, d_rd_empty, d_ae, d_udf;
    logic [255:0] d_wr_data;
    logic [31:0]  d_rd_data;
    logic [8:0]   d_wl, d_af_num;
    logic [11:0]  d_rl, d_ae_num;

    logic         u_wr_en, u_rd_en, u_wr_full, u_af, u_ovf, u_rd_empty, u_ae, u_udf;
    logic [31:0]  u_wr_data;
    logic [255:0] u_rd_data;
    logic [6:0]   u_wl, u_af_num;
    logic [3:0]   u_rl, u_ae_num;

    sync_width_conv_fifo dut_dn (
        .clk(clk), .rst(rst),
        .wr_en(d_wr_en), .wr_data(d_wr_data), .wr_full(d_wr_full), .almost_full(d_af),
        .wr_water_level(d_wl), .almost_full_num(d_af_num), .wr_overflow(d_ovf),
        .rd_en(d_rd_en), .rd_data(d_rd_data), .rd_empty(d_rd_empty), .almost_empty(d_ae),
        .rd_water_level(d_rl), .almost_empty_num(d_ae_num), .rd_underflow(d_udf)
    );

    sync_width_conv_fifo #(
        .WR_DATA_WIDTH(32), .RD_DATA_WIDTH(256), .WR_DEPTH_WIDTH(6), .OUTPUT_REG(1)
    ) dut_up (
        .clk(clk), .rst(rst),
        .wr_en(u_wr_en), .wr_data(u_wr_data), .wr_full(u_wr_full), .almost_full(u_af),
        .wr_water_level(u_wl), .almost_full_num(u_af_num), .wr_overflow(u_ovf),
        .rd_en(u_rd_en), .rd_data(u_rd_data), .rd_empty(u_rd_empty), .almost_empty(u_ae),
        .rd_water_level(u_rl), .almost_empty_num(u_ae_num), .rd_underflow(u_udf)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [255:0] word8(input int base);
        logic [255:0] w;
        for (int j = 0; j < 8; j++) w[j*32 +: 32] = 32'(base + j);
        return w;
    endfunction

    // Model of the 256->32 FIFO: a queue of 32-bit words, capacity 2048.
    logic [31:0] mq[$];
    logic [31:0] m_rd = '0;
    bit          m_ovf = 1'b0, m_udf = 1'b0;
    int          m_af_num = 0, m_ae_num = 0;

    always @(posedge clk) begin
        int n;
        n = mq.size();
        m_af_num = int'(d_af_num);
        m_ae_num = int'(d_ae_num);
        if (rst) begin
            mq.delete();
            m_rd  = '0;
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            m_ovf = d_wr_en && (2048 - n < 8);
            m_udf = d_rd_en && (n < 1);
            if (d_rd_en && n >= 1) m_rd = mq.pop_front();
            if (d_wr_en && 2048 - n >= 8)
                for (int j = 0; j < 8; j++) mq.push_back(d_wr_data[j*32 +: 32]);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            int n, wl;
            n  = mq.size();
            wl = (n + 7) / 8;
            chk("m_wr_full",     256'(d_wr_full),  256'((2048 - n) < 8));
            chk("m_rd_empty",    256'(d_rd_empty), 256'(n < 1));
            chk("m_wr_level",    256'(d_wl),       256'(wl));
            chk("m_rd_level",    256'(d_rl),       256'(n));
            chk("m_almost_full", 256'(d_af),       256'(wl >= m_af_num));
            chk("m_almost_empty",256'(d_ae),       256'(n <= m_ae_num));
            chk("m_overflow",    256'(d_ovf),      256'(m_ovf));
            chk("m_underflow",   256'(d_udf),      256'(m_udf));
            chk("m_rd_data",     256'(d_rd_data),  256'(m_rd));
        end
    end

    initial begin
        logic [255:0] exp_up;
        rst = 1'b1;
        d_wr_en = 1'b0; d_rd_en = 1'b0; d_wr_data = '0; d_af_num = '0; d_ae_num = 12'd4;
        u_wr_en = 1'b0; u_rd_en = 1'b0; u_wr_data = '0; u_af_num = 7'd60; u_ae_num = '0;
        tick();
        tick();
        chk_en = 1'b1;
        chk("rst_almost_full_num0", 256'(d_af), 256'(1));
        chk("rst_rd_empty", 256'(d_rd_empty), 256'(1));
        chk("rst_almost_empty", 256'(d_ae), 256'(1));
        chk("rst_wr_full", 256'(d_wr_full), 256'(0));
        chk("rst_rd_data", 256'(d_rd_data), 256'(0));
        chk("up_rst_rd_empty", 256'(u_rd_empty), 256'(1));
        rst = 1'b0;
        d_af_num = 9'd300;

        // 32->256: partial words stay invisible until the eighth lane lands.
        u_wr_en = 1'b1;
        for (int k = 0; k < 7; k++) begin
            u_wr_data = 32'hA000_0000 + 32'(k);
            tick();
        end
        chk("up_7w_rd_empty", 256'(u_rd_empty), 256'(1));
        chk("up_7w_wr_level", 256'(u_wl), 256'(7));
        chk("up_7w_rd_level", 256'(u_rl), 256'(0));
        u_wr_data = 32'hA000_0007;
        tick();
        u_wr_en = 1'b0;
        chk("up_8w_rd_empty", 256'(u_rd_empty), 256'(0));
        chk("up_8w_rd_level", 256'(u_rl), 256'(1));
        chk("up_8w_wr_level", 256'(u_wl), 256'(8));
        u_rd_en = 1'b1;
        tick();
        u_rd_en = 1'b0;
        chk("up_rd_empty_after", 256'(u_rd_empty), 256'(1));
        chk("up_latency1_data", u_rd_data, 256'(0));
        tick();
        for (int k = 0; k < 8; k++) exp_up[k*32 +: 32] = 32'hA000_0000 + 32'(k);
        chk("up_packed_data", u_rd_data, exp_up);
        u_wr_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            u_wr_data = 32'hB000_0000 + 32'(k);
            tick();
        end
        u_wr_en = 1'b0;
        u_rd_en = 1'b1;
        tick();
        u_rd_en = 1'b0;
        chk("up_partial_underflow", 256'(u_udf), 256'(1));
        chk("up_partial_rd_empty", 256'(u_rd_empty), 256'(1));
        chk("up_partial_wr_level", 256'(u_wl), 256'(3));
        tick();
        chk("up_data_held", u_rd_data, exp_up);
        chk("up_underflow_clear", 256'(u_udf), 256'(0));
        chk("up_almost_full", 256'(u_af), 256'(0));
        chk("up_almost_empty", 256'(u_ae), 256'(1));
        chk("up_wr_full", 256'(u_wr_full), 256'(0));
        chk("up_overflow", 256'(u_ovf), 256'(0));

        // 256->32: fill to capacity, then one rejected write.
        d_wr_en = 1'b1;
        for (int k = 0; k < 256; k++) begin
            d_wr_data = word8(k * 8);
            tick();
        end
        chk("fill_wr_full", 256'(d_wr_full), 256'(1));
        chk("fill_wr_level", 256'(d_wl), 256'(256));
        chk("fill_rd_level", 256'(d_rl), 256'(2048));
        d_wr_data = word8(9999);
        tick();
        d_wr_en = 1'b0;
        chk("fill_overflow", 256'(d_ovf), 256'(1));
        chk("fill_no_change", 256'(d_rl), 256'(2048));
        tick();
        chk("fill_overflow_1cyc", 256'(d_ovf), 256'(0));

        d_rd_en = 1'b1;
        for (int k = 0; k < 2048; k++) tick();
        chk("drain_last_data", 256'(d_rd_data), 256'(2047));
        chk("drain_rd_empty", 256'(d_rd_empty), 256'(1));
        tick();
        chk("drain_underflow", 256'(d_udf), 256'(1));
        d_rd_en = 1'b0;

        // One wide word read out lane 0 first.
        d_wr_en = 1'b1;
        d_wr_data = word8(0);
        tick();
        d_wr_en = 1'b0;
        d_rd_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("lane_order_%0d", i), 256'(d_rd_data), 256'(i));
        end
        chk("lane_rd_empty", 256'(d_rd_empty), 256'(1));
        tick();
        chk("lane_underflow", 256'(d_udf), 256'(1));
        d_rd_en = 1'b0;
        tick();
        chk("lane_data_held", 256'(d_rd_data), 256'(7));

        // Simultaneous traffic at 100 write words: +8 narrow in, -1 narrow out per cycle.
        d_wr_en = 1'b1;
        for (int k = 0; k < 100; k++) begin
            d_wr_data = word8(4096 + k * 8);
            tick();
        end
        d_rd_en = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            d_wr_data = word8(8192 + k * 8);
            tick();
            if (k < 8) chk($sformatf("sim_wr_level_%0d", k), 256'(d_wl), 256'(100 + k));
        end
        d_wr_en = 1'b0;
        d_rd_en = 1'b0;
        d_ae_num = 12'd856;
        tick();
        chk("ae_at_threshold", 256'(d_ae), 256'(1));
        d_ae_num = 12'd855;
        tick();
        chk("ae_above_threshold", 256'(d_ae), 256'(0));

        // Almost-full threshold crossing and runtime change.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        d_af_num = 9'd10;
        d_wr_en = 1'b1;
        for (int k = 0; k < 9; k++) begin
            d_wr_data = word8(16384 + k * 8);
            tick();
        end
        chk("af_at_9", 256'(d_af), 256'(0));
        tick();
        chk("af_at_10", 256'(d_af), 256'(1));
        d_wr_en = 1'b0;
        d_af_num = 9'd11;
        tick();
        chk("af_raise_thresh", 256'(d_af), 256'(0));
        d_af_num = 9'd5;
        tick();
        chk("af_lower_thresh", 256'(d_af), 256'(1));

        // Reset at 37 entries with a write pending.
        d_wr_en = 1'b1;
        for (int k = 0; k < 27; k++) begin
            d_wr_data = word8(20000 + k * 8);
            tick();
        end
        chk("pre_rst_level", 256'(d_wl), 256'(37));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        d_wr_en = 1'b0;
        chk("rst_mid_rd_empty", 256'(d_rd_empty), 256'(1));
        chk("rst_mid_wr_level", 256'(d_wl), 256'(0));
        chk("rst_mid_rd_level", 256'(d_rl), 256'(0));
        chk("rst_mid_overflow", 256'(d_ovf), 256'(0));
        d_wr_en = 1'b1;
        d_wr_data = word8(32'h5000);
        tick();
        d_wr_en = 1'b0;
        d_rd_en = 1'b1;
        tick();
        d_rd_en = 1'b0;
        chk("post_rst_lane0", 256'(d_rd_data), 256'(32'h5000));
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
